mac_ieee_out: RTL and testbench
===============================

Name: mac_ieee_out

Overview:
- Output stage of the SpMV multiply-accumulate unit, directly downstream of the intermediator.
- Consumes finished 66-bit FloPoCo row sums pushed by the intermediator and converts them to IEEE-754 binary64.
- Buffers results in a FIFO and presents them to the memory-write side with a valid/ready handshake.
- Tracks end-of-file and asserts done once every result has been delivered.

Parameters:
- FIFO_DEPTH, 64, result FIFO entries; power of two, >= 4.
- LOG2_FIFO_DEPTH, log2(FIFO_DEPTH-1), FIFO pointer width.
- AF_MARGIN, 8, almost_full asserts when free entries <= AF_MARGIN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- push_in  in  1  result valid from intermediator; no backpressure
- v_in  in  66  FloPoCo value: [65:64] exception (00 zero, 01 normal, 10 inf, 11 NaN), [63] sign, [62:52] exponent, [51:0] fraction
- eof_in  in  1  one-cycle pulse; no further push_in for this matrix
- out_valid  out  1  out_data holds a valid result
- out_ready  in  1  downstream accepts out_data
- out_data  out  64  IEEE-754 binary64 result
- almost_full  out  1  free FIFO entries <= AF_MARGIN
- overflow  out  1  sticky; a result was dropped
- done  out  1  all results of the current matrix delivered
- out_count  out  32  results delivered (see Optional Feature)

Behaviour:
- Reset: every output is 0; FIFO empty; conversion stage invalid; FSM in RUN. Asserting rst mid-operation discards all buffered and in-flight data immediately.
- Conversion stage: one register stage that captures push_in/v_in every cycle.
  - zero: {sign, 63'b0}
  - normal: {sign, exp, frac}
  - inf: {sign, 11'h7FF, 52'b0}
  - NaN: 64'h7FF8000000000000, sign ignored
- FIFO write: happens at the edge after capture.
  - Latency: push_in high in cycle t gives out_valid in cycle t+2 when the FIFO was empty.
  - Throughput: one result per cycle.
- FIFO read: first-word-fall-through.
  - out_valid equals FIFO not empty; out_data is the head entry.
  - Pop when out_valid && out_ready.
  - out_data and out_valid must stay stable while out_valid && !out_ready.
- Full:
  - A write is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow sets; overflow clears only on rst.
- Empty: out_ready is ignored while the FIFO is empty.
- Pointers: wrap modulo FIFO_DEPTH; an occupancy counter of width LOG2_FIFO_DEPTH+1 distinguishes full from empty.
- FSM states and transitions:
  - RUN -> DRAIN on eof_in.
  - DRAIN -> DONE when the conversion stage is invalid, no push is pending, and the FIFO is empty (a pop of the last entry counts). done is asserted from the cycle after that pop.
  - DONE -> RUN on push_in. done clears in the same cycle the push is sampled.
  - eof_in while in DRAIN or DONE is ignored.
  - eof_in in the same cycle as push_in: that push belongs to the current matrix and must drain before DONE.
  - eof_in with no results pending gives DONE two cycles later.
- push_in during DRAIN is a protocol error; it is still converted and delivered, and delays DONE.

Optional Feature:
- Macro: MAC_IEEE_OUT_COUNT_EN.
- Defined:
  - out_count increments on each pop, saturating at 32'hFFFFFFFF.
  - Resets to 0 on rst and on the DONE->RUN transition.
  - Holds its value while in DONE.
- Undefined: out_count is constant 0 and the counter logic is not synthesised.

Test Plan:
- Conversion: push {2'b01,1'b0,11'h3FF,52'h0}, then {2'b00,1'b1,...}, {2'b10,1'b1,...}, {2'b11,...}, with out_ready=1 -> out_data 3FF0000000000000, 8000000000000000, FFF0000000000000, 7FF8000000000000 in order; first out_valid 2 cycles after the first push.
- Backpressure: out_ready=0, push 70 consecutive values 1..70 as normals -> almost_full when free <= 8; full after 64; last 6 dropped, overflow=1; then out_ready=1 -> exactly 64 results in order, done stays 0.
- Simultaneous full-and-pop: FIFO full, push_in and out_ready high in the same cycle -> no drop, overflow stays 0, occupancy stays 64.
- EOF drain: push 3 values, eof_in in the same cycle as the 3rd, out_ready toggling 1010... -> done asserts the cycle after the 3rd pop; out_count=3 (macro defined); next push clears done and out_count.
- Empty EOF: eof_in with nothing pending -> done=1 two cycles later.
- Reset mid-drain: rst asserted with 10 entries buffered in DRAIN -> out_valid=0, done=0, overflow=0 asynchronously; after release, a single push gives one output 2 cycles later.

Source files
------------

// File: rtl/mac_ieee_out.sv
// mac_ieee_out
//   Output stage of the SpMV multiply-accumulate unit. Converts 66-bit FloPoCo
//   row sums from the intermediator into IEEE-754 binary64. Results are buffered in a
//   first-word-fall-through FIFO and handed to the memory-write side through a
//   valid/ready handshake. The block tracks end-of-file and raises done once
//   every result of the matrix has been delivered.
//
//   Optional feature macro: MAC_IEEE_OUT_COUNT_EN
//     defined   : out_count counts delivered results, saturating at all-ones,
//                 cleared on rst and when a new matrix starts (DONE -> RUN).
//     undefined : out_count is tied to 0 and no counter is built.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   push_in      result valid from intermediator (no backpressure)
//   v_in[65:0]   FloPoCo value {exc[1:0], sign, exp[10:0], frac[51:0]}
//   eof_in       one-cycle end-of-matrix pulse
//   out_valid    out_data holds a valid result (FIFO not empty)
//   out_ready    downstream accepts out_data
//   out_data     IEEE-754 binary64 head-of-FIFO result
//   almost_full  free FIFO entries <= AF_MARGIN
//   overflow     sticky: a result was dropped because the FIFO was full
//   done         all results of the current matrix delivered
//   out_count    number of delivered results (optional feature)
module mac_ieee_out #(
   parameter int FIFO_DEPTH      = 64,
   parameter int LOG2_FIFO_DEPTH = $clog2(FIFO_DEPTH - 1),
   parameter int AF_MARGIN       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_in,
   input  logic [65:0] v_in,
   input  logic        eof_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        almost_full,
   output logic        overflow,
   output logic        done,
   output logic [31:0] out_count
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

   localparam logic [LOG2_FIFO_DEPTH:0]   CNT_FULL = FIFO_DEPTH[LOG2_FIFO_DEPTH:0];
   localparam logic [LOG2_FIFO_DEPTH:0]   AF_LEVEL = AF_MARGIN[LOG2_FIFO_DEPTH:0];
   localparam logic [LOG2_FIFO_DEPTH:0]   CNT_ONE  = 1;
   localparam logic [LOG2_FIFO_DEPTH-1:0] PTR_ONE  = 1;

   // Conversion stage
   logic        conv_valid_q, conv_valid_d;
   logic [63:0] conv_data_q,  conv_data_d;

   // FIFO
   logic [63:0]                mem [FIFO_DEPTH];
   logic [LOG2_FIFO_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG2_FIFO_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LOG2_FIFO_DEPTH:0]   count_q,  count_d;
   logic                       fifo_full, pop, wr_en, drop;

   // Control
   state_t state_q, state_d;
   logic   done_q,  done_d;
   logic   overflow_q, overflow_d;

   // FloPoCo -> binary64. NaN is canonicalised to a quiet NaN with sign cleared.
   always_comb begin
      conv_valid_d = push_in;
      case (v_in[65:64])
         2'b00:   conv_data_d = {v_in[63], 63'b0};
         2'b01:   conv_data_d = v_in[63:0];
         2'b10:   conv_data_d = {v_in[63], 11'h7FF, 52'b0};
         default: conv_data_d = 64'h7FF8_0000_0000_0000;
      endcase
   end

   assign fifo_full   = (count_q == CNT_FULL);
   assign out_valid   = (count_q != '0);
   assign pop         = out_valid && out_ready;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign wr_en       = conv_valid_q && (!fifo_full || pop);
   assign drop        = conv_valid_q && fifo_full && !pop;
   assign almost_full = ((CNT_FULL - count_q) <= AF_LEVEL);
   // Gate the head so the output reads 0 while empty (RAM content is undefined).
   assign out_data    = out_valid ? mem[rd_ptr_q] : 64'b0;
   assign overflow    = overflow_q;
   assign done        = done_q;

   always_comb begin
      wr_ptr_d   = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d   = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      overflow_d = overflow_q || drop;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Drain completes on the edge that leaves the FIFO empty with nothing in
   // flight, so done shows up the cycle after the final pop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (eof_in) state_d = ST_DRAIN;
         ST_DRAIN: if (!conv_valid_q && !push_in && (count_d == '0)) state_d = ST_DONE;
         ST_DONE:  if (push_in) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
      done_d = (state_d == ST_DONE);
   end

   // Storage array: no reset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= conv_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conv_valid_q <= 1'b0;
         conv_data_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         state_q      <= ST_RUN;
         done_q       <= 1'b0;
      end else begin
         conv_valid_q <= conv_valid_d;
         conv_data_q  <= conv_data_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         state_q      <= state_d;
         done_q       <= done_d;
      end
   end

`ifdef MAC_IEEE_OUT_COUNT_EN
   logic [31:0] out_count_q, out_count_d;

   always_comb begin
      out_count_d = out_count_q;
      if (state_q == ST_DONE) begin
         if (push_in) out_count_d = '0;
      end else if (pop && (out_count_q != 32'hFFFF_FFFF)) begin
         out_count_d = out_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) out_count_q <= '0;
      else     out_count_q <= out_count_d;
   end

   assign out_count = out_count_q;
`else
   assign out_count = 32'd0;
`endif

endmodule

// File: tb/tb_mac_ieee_out.sv
module tb_mac_ieee_out;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push_in = 1'b0;
   logic [65:0] v_in = '0;
   logic        eof_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic        almost_full;
   logic        overflow;
   logic        done;
   logic [31:0] out_count;

   int n_checks = 0;
   int n_fail   = 0;
   int pop_cnt  = 0;
   logic [63:0] sb[$];
   logic        stall_q = 1'b0;
   logic [63:0] stall_data = '0;

   always #5 clk = ~clk;

   mac_ieee_out dut (
      .clk(clk), .rst(rst), .push_in(push_in), .v_in(v_in), .eof_in(eof_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .almost_full(almost_full), .overflow(overflow), .done(done), .out_count(out_count)
   );

   // Scoreboard monitor: compares every pop and checks hold-while-stalled.
   always @(negedge clk) begin
      logic [63:0] exp_v;
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== stall_data) begin
               n_fail++;
               $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, stall_data);
            end
         end
         if (out_valid && out_ready) begin
            n_checks++;
            pop_cnt++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL pop_unexpected: data=%h, required no pop", out_data);
            end else begin
               exp_v = sb.pop_front();
               if (out_data !== exp_v) begin
                  n_fail++;
                  $display("FAIL pop_data: got %h, required %h", out_data, exp_v);
               end else begin
                  $display("pop %0d data=%h ok", pop_cnt, out_data);
               end
            end
         end
         stall_q    = out_valid && !out_ready;
         stall_data = out_data;
      end
   end

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({out_valid, almost_full, overflow, done} !== 4'b0 || out_data !== 64'd0 || out_count !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: v=%b af=%b ov=%b d=%b data=%h cnt=%0d, required all 0",
                  out_valid, almost_full, overflow, done, out_data, out_count);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: v=%b d=%b, required 0 0", out_valid, done);
      end
   endtask

   task automatic test_conversion();
      logic [65:0] cv [4];
      logic [63:0] ce [4];
      cv[0] = {2'b01, 1'b0, 11'h3FF, 52'h0};           ce[0] = 64'h3FF0_0000_0000_0000;
      cv[1] = {2'b00, 1'b1, 11'h123, 52'hABC};         ce[1] = 64'h8000_0000_0000_0000;
      cv[2] = {2'b10, 1'b1, 11'h055, 52'h1234};        ce[2] = 64'hFFF0_0000_0000_0000;
      cv[3] = {2'b11, 1'b1, 11'h001, 52'hF};           ce[3] = 64'h7FF8_0000_0000_0000;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         push_in = 1'b1; v_in = cv[i]; out_ready = 1'b1;
         sb.push_back(ce[i]);
         @(negedge clk);
         if (i < 3) begin
            n_checks++;
            if (out_valid !== (i == 2)) begin
               n_fail++;
               $display("FAIL conv_latency: cycle t+%0d out_valid=%b, required %b", i, out_valid, (i == 2));
            end
         end
      end
      @(posedge clk); #1 push_in = 1'b0;
      for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL conv_drain: %0d outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_backpressure();
      int p0;
      out_ready = 1'b0;
      for (int i = 1; i <= 70; i++) begin
         @(posedge clk); #1;
         push_in = 1'b1;
         v_in = {2'b01, 1'b0, 11'(i), 52'(i * 3)};
         if (i <= 64) sb.push_back({1'b0, 11'(i), 52'(i * 3)});
         @(negedge clk);
         // Occupancy during push i is i-2.
         if (i == 57 || i == 58) begin
            n_checks++;
            if (almost_full !== (i == 58)) begin
               n_fail++;
               $display("FAIL bp_almost_full: occ=%0d af=%b, required %b", i - 2, almost_full, (i == 58));
            end
         end
         if (i == 66 || i == 67) begin
            n_checks++;
            if (overflow !== (i == 67)) begin
               n_fail++;
               $display("FAIL bp_overflow: push %0d ov=%b, required %b", i, overflow, (i == 67));
            end
         end
      end
      @(posedge clk); #1 push_in = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({almost_full, overflow, out_valid, done} !== 4'b1110) begin
         n_fail++;
         $display("FAIL bp_full_state: af=%b ov=%b v=%b d=%b, required 1 1 1 0", almost_full, overflow, out_valid, done);
      end
      p0 = pop_cnt;
      @(posedge clk); #1 out_ready = 1'b1;
      for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
      repeat (4) @(negedge clk);
      n_checks++;
      if (pop_cnt - p0 != 64 || sb.size() != 0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: pops=%0d left=%0d done=%b, required 64 0 0", pop_cnt - p0, sb.size(), done);
      end
   endtask

   task automatic test_full_and_pop();
      int p0;
      @(posedge clk); #1 rst = 1'b1;
      sb.delete();
      @(posedge clk); #1 rst = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #1;
         push_in = 1'b1;
         v_in = {2'b01, 1'b1, 11'(i + 100), 52'(i + 7)};
         sb.push_back({1'b1, 11'(i + 100), 52'(i + 7)});
      end
      @(posedge clk); #1 push_in = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (almost_full !== 1'b1 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL fp_filled: af=%b ov=%b, required 1 0", almost_full, overflow);
      end
      // Push lands in the conversion stage; the next cycle writes while popping.
      @(posedge clk); #1 push_in = 1'b1; v_in = {2'b01, 1'b0, 11'h200, 52'h5A5};
      sb.push_back({1'b0, 11'h200, 52'h5A5});
      @(posedge clk); #1 push_in = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (overflow !== 1'b0 || almost_full !== 1'b1) begin
         n_fail++;
         $display("FAIL fp_no_drop: ov=%b af=%b, required 0 1", overflow, almost_full);
      end
      p0 = pop_cnt;
      @(posedge clk); #1 out_ready = 1'b1;
      for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      n_checks++;
      if (pop_cnt - p0 != 64 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL fp_occupancy: pops=%0d left=%0d, required 64 0", pop_cnt - p0, sb.size());
      end
   endtask

   task automatic test_eof_drain();
      int  pops = 0;
      bit  seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         out_ready = (c % 2 == 0);
         push_in   = (c < 3);
         eof_in    = (c == 2);
         v_in      = {2'b01, 1'b0, 11'(c + 1), 52'(c + 40)};
         if (c < 3) sb.push_back({1'b0, 11'(c + 1), 52'(c + 40)});
         @(negedge clk);
         if (pops == 3 && !seen) begin
            seen = 1'b1;
            n_checks++;
            if (done !== 1'b1) begin
               n_fail++;
               $display("FAIL eof_done_rise: done=%b after 3rd pop, required 1", done);
            end
         end else if (pops < 3 && done !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL eof_done_early: done=%b with %0d pops, required 0", done, pops);
         end
         if (out_valid && out_ready) pops++;
      end
      n_checks++;
      if (!seen || done !== 1'b1) begin
         n_fail++;
         $display("FAIL eof_done_final: seen=%b done=%b, required 1 1", seen, done);
      end
      n_checks++;
`ifdef MAC_IEEE_OUT_COUNT_EN
      if (out_count !== 32'd3) begin
         n_fail++;
         $display("FAIL eof_count: out_count=%0d, required 3", out_count);
      end
`else
      if (out_count !== 32'd0) begin
         n_fail++;
         $display("FAIL eof_count: out_count=%0d, required 0", out_count);
      end
`endif
      @(posedge clk); #1 push_in = 1'b1; out_ready = 1'b1; v_in = {2'b01, 1'b0, 11'h7, 52'h9};
      sb.push_back({1'b0, 11'h7, 52'h9});
      @(posedge clk); #1 push_in = 1'b0;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || out_count !== 32'd0) begin
         n_fail++;
         $display("FAIL eof_restart: done=%b out_count=%0d, required 0 0", done, out_count);
      end
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL eof_restart_drain: %0d outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_empty_eof();
      repeat (3) @(posedge clk);
      #1 eof_in = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (done !== (c == 2)) begin
            n_fail++;
            $display("FAIL empty_eof: cycle t+%0d done=%b, required %b", c, done, (c == 2));
         end
         @(posedge clk); #1 eof_in = 1'b0;
      end
   endtask

   task automatic test_reset_mid_drain();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         push_in = 1'b1; eof_in = (i == 9);
         v_in = {2'b01, 1'b0, 11'(i + 300), 52'(i)};
         sb.push_back({1'b0, 11'(i + 300), 52'(i)});
      end
      @(posedge clk); #1 push_in = 1'b0; eof_in = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL rmd_buffered: v=%b d=%b, required 1 0", out_valid, done);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, done, overflow, almost_full} !== 4'b0 || out_data !== 64'd0) begin
         n_fail++;
         $display("FAIL rmd_async: v=%b d=%b ov=%b af=%b data=%h, required all 0",
                  out_valid, done, overflow, almost_full, out_data);
      end
      sb.delete();
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 push_in = 1'b1; out_ready = 1'b1; v_in = {2'b01, 1'b1, 11'h400, 52'hC0FFEE};
      sb.push_back({1'b1, 11'h400, 52'hC0FFEE});
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== (c == 2)) begin
            n_fail++;
            $display("FAIL rmd_latency: cycle t+%0d out_valid=%b, required %b", c, out_valid, (c == 2));
         end
         @(posedge clk); #1 push_in = 1'b0;
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL rmd_single: v=%b left=%0d, required 0 0", out_valid, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_conversion();
      test_backpressure();
      test_full_and_pop();
      test_eof_drain();
      test_empty_eof();
      test_reset_mid_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
